// File: rtl/cpu_defs.sv
// Shared EX-stage definitions for the multiply/divide unit: opcodes, FSM
// state encodings and the step-size legality helper.
package cpu_defs;

    typedef enum logic [2:0] {
        MD_MULTU = 3'b000,
        MD_MULT  = 3'b001,
        MD_DIVU  = 3'b010,
        MD_DIV   = 3'b011,
        MD_MADDU = 3'b100,
        MD_MADD  = 3'b101,
        MD_MSUBU = 3'b110,
        MD_MSUB  = 3'b111
    } md_op_e;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_MUL  = S_MUL,
        ST_DIV  = S_DIV,
        ST_FIX  = S_FIX,
        ST_DONE = S_DONE
    } md_state_e;

    // Bit n set means a step of n bits per cycle is supported.
    localparam int MUL_STEP_LEGAL_MASK = 32'h0000_0016;
    localparam int DIV_STEP_LEGAL_MASK = 32'h0000_0006;

    function automatic logic md_step_legal(input int step, input int width, input int mask);
        logic [31:0] mask_v;
        mask_v = mask;
        if ((step < 1) || (step > 31)) begin
            return 1'b0;
        end else begin
            return mask_v[step] && ((width % step) == 0);
        end
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One combinational restoring-divide iteration retiring STEP quotient bits,
// most significant dividend bit first.
module md_div_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [STEP-1:0]  dvd_bits,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [STEP-1:0]  quo_bits
);

    logic [WIDTH-1:0] rem_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;

    // Partial remainder stays below the divisor, so the trial value fits in
    // WIDTH+1 bits and the top bit of the difference is the borrow.
    always_comb begin
        rem_s    = rem_in;
        trial_s  = {(WIDTH+1){1'b0}};
        diff_s   = {(WIDTH+1){1'b0}};
        quo_bits = {STEP{1'b0}};
        for (int i = STEP - 1; i >= 0; i--) begin
            trial_s = {rem_s, dvd_bits[i]};
            diff_s  = trial_s - {1'b0, divisor};
            if (!diff_s[WIDTH]) begin
                rem_s       = diff_s[WIDTH-1:0];
                quo_bits[i] = 1'b1;
            end else begin
                rem_s       = trial_s[WIDTH-1:0];
            end
        end
        rem_out = rem_s;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. A single 2*WIDTH shift
// register carries the shift-add product or the remainder/quotient pair.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2,
    parameter int DIV_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0] in_hi,
    input  logic [WIDTH-1:0] in_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_by_zero
);

    import cpu_defs::*;

    localparam int NM    = WIDTH / MUL_STEP;
    localparam int ND    = WIDTH / DIV_STEP;
    localparam int CNT_W = $clog2((NM > ND) ? NM : ND) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MUL_N = CNT_W'(NM - 1);
    localparam logic [CNT_W-1:0] CNT_DIV_N = CNT_W'(ND - 1);

    if ((WIDTH % 2) != 0) begin : g_bad_width
        $fatal(1, "muldiv_unit: WIDTH must be even");
    end
    if (!md_step_legal(MUL_STEP, WIDTH, MUL_STEP_LEGAL_MASK)) begin : g_bad_mul_step
        $fatal(1, "muldiv_unit: MUL_STEP must be 1, 2 or 4 and divide WIDTH");
    end
    if (!md_step_legal(DIV_STEP, WIDTH, DIV_STEP_LEGAL_MASK)) begin : g_bad_div_step
        $fatal(1, "muldiv_unit: DIV_STEP must be 1 or 2 and divide WIDTH");
    end

    logic [2:0]           state_r;
    logic [2:0]           next_state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   p_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mag_a_r;
    logic [WIDTH-1:0]     mag_b_r;
    logic                 div_r;
    logic                 acc_mode_r;
    logic                 sub_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic                 dbz_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 div_by_zero_r;
    logic                 out_valid_r;
    logic                 busy_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 is_div_in_s;
    logic                 dbz_in_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [MUL_STEP-1:0]  digit_s;
    logic [WIDTH+MUL_STEP-1:0] pp_s;
    logic [WIDTH+MUL_STEP-1:0] sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [WIDTH-1:0]     div_rem_s;
    logic [DIV_STEP-1:0]  div_quo_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;
    logic [2*WIDTH-1:0]   fix_s;

    // Request decode: acceptance, operation class and operand magnitudes.
    always_comb begin
        in_ready_s  = (state_r == S_IDLE) && !flush;
        accept_s    = in_valid && in_ready_s;
        is_div_in_s = (op == MD_DIVU) || (op == MD_DIV);
        dbz_in_s    = is_div_in_s && (srcb == {WIDTH{1'b0}});
        sign_a_s    = op[0] && srca[WIDTH-1];
        sign_b_s    = op[0] && srcb[WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = -srca;
        end else begin
            mag_a_s = srca;
        end
        if (sign_b_s) begin
            mag_b_s = -srcb;
        end else begin
            mag_b_s = srcb;
        end
    end

    // Shift-add multiply step: low half of p_r holds the remaining multiplier.
    always_comb begin
        digit_s = p_r[MUL_STEP-1:0];
        pp_s    = {(WIDTH+MUL_STEP){1'b0}};
        for (int i = 0; i < MUL_STEP; i++) begin
            if (digit_s[i]) begin
                pp_s = pp_s + ({{MUL_STEP{1'b0}}, mag_a_r} << i);
            end else begin
                pp_s = pp_s;
            end
        end
        sum_s      = {{MUL_STEP{1'b0}}, p_r[2*WIDTH-1:WIDTH]} + pp_s;
        mul_next_s = {sum_s, p_r[WIDTH-1:MUL_STEP]};
    end

    md_div_step #(
        .WIDTH (WIDTH),
        .STEP  (DIV_STEP)
    ) u_div_step (
        .rem_in   (p_r[2*WIDTH-1:WIDTH]),
        .dvd_bits (p_r[WIDTH-1 -: DIV_STEP]),
        .divisor  (mag_b_r),
        .rem_out  (div_rem_s),
        .quo_bits (div_quo_s)
    );

    assign div_next_s = {div_rem_s, p_r[WIDTH-DIV_STEP-1:0], div_quo_s};

    // Sign correction and accumulate; the sums wrap modulo 2^(2*WIDTH).
    always_comb begin
        if (neg_res_r) begin
            prod_s    = -p_r;
            quo_fix_s = -p_r[WIDTH-1:0];
        end else begin
            prod_s    = p_r;
            quo_fix_s = p_r[WIDTH-1:0];
        end
        if (neg_rem_r) begin
            rem_fix_s = -p_r[2*WIDTH-1:WIDTH];
        end else begin
            rem_fix_s = p_r[2*WIDTH-1:WIDTH];
        end
        if (dbz_r) begin
            fix_s = p_r;
        end else if (div_r) begin
            fix_s = {rem_fix_s, quo_fix_s};
        end else if (acc_mode_r) begin
            if (sub_r) begin
                fix_s = acc_r - prod_s;
            end else begin
                fix_s = acc_r + prod_s;
            end
        end else begin
            fix_s = prod_s;
        end
    end

    // Next-state logic; flush aborts from every non-idle state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (dbz_in_s) begin
                        next_state_s = S_FIX;
                    end else if (is_div_in_s) begin
                        next_state_s = S_DIV;
                    end else begin
                        next_state_s = S_MUL;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    next_state_s = S_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    next_state_s = S_FIX;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_FIX: begin
                if (flush) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Control registers: state, iteration counter and registered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_ZERO;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= (next_state_s == S_DONE);
            busy_r      <= (next_state_s != S_IDLE);
            if (accept_s) begin
                cnt_r <= is_div_in_s ? CNT_DIV_N : CNT_MUL_N;
            end else if ((state_r == S_MUL) || (state_r == S_DIV)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Operand capture at acceptance, then the shared shift register iterates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_a_r    <= {WIDTH{1'b0}};
            mag_b_r    <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            p_r        <= {(2*WIDTH){1'b0}};
            div_r      <= 1'b0;
            acc_mode_r <= 1'b0;
            sub_r      <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            dbz_r      <= 1'b0;
        end else if (accept_s) begin
            mag_a_r    <= mag_a_s;
            mag_b_r    <= mag_b_s;
            acc_r      <= {in_hi, in_lo};
            div_r      <= is_div_in_s;
            acc_mode_r <= op[2];
            sub_r      <= op[2] && op[1];
            neg_res_r  <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
            dbz_r      <= dbz_in_s;
            if (dbz_in_s) begin
                p_r <= {srca, {WIDTH{1'b1}}};
            end else if (is_div_in_s) begin
                p_r <= {{WIDTH{1'b0}}, mag_a_s};
            end else begin
                p_r <= {{WIDTH{1'b0}}, mag_b_s};
            end
        end else if (state_r == S_MUL) begin
            p_r <= mul_next_s;
        end else if (state_r == S_DIV) begin
            p_r <= div_next_s;
        end else begin
            p_r <= p_r;
        end
    end

    // Result registers load only in FIX, so hi/lo hold through DONE and aborts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r          <= {WIDTH{1'b0}};
            lo_r          <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
        end else if ((state_r == S_FIX) && !flush) begin
            hi_r          <= fix_s[2*WIDTH-1:WIDTH];
            lo_r          <= fix_s[WIDTH-1:0];
            div_by_zero_r <= dbz_r;
        end else begin
            hi_r          <= hi_r;
            lo_r          <= lo_r;
            div_by_zero_r <= div_by_zero_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a vector table run through a
// scoreboard queue, plus hand-written flush, stall and reset sequences.
module tb_muldiv_unit;

    localparam int W         = 32;
    localparam int LAT_LIMIT = 100;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ih;
        logic [W-1:0] il;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dbz;
        int           exp_lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] srca = 32'd0;
    logic [W-1:0] srcb = 32'd0;
    logic [W-1:0] in_hi = 32'd0;
    logic [W-1:0] in_lo = 32'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         div_by_zero;

    int   n_vec = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[12];
    vec_t sb_q[$];

    muldiv_unit #(.WIDTH(W), .MUL_STEP(2), .DIV_STEP(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .srca        (srca),
        .srcb        (srcb),
        .in_hi       (in_hi),
        .in_lo       (in_lo),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request and return just after the accepting edge.
    task automatic start_op(input vec_t v, output bit ok);
        int w;
        @(negedge clk);
        op = v.op; srca = v.a; srcb = v.b; in_hi = v.ih; in_lo = v.il;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < LAT_LIMIT) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    // lat is the edge number (accept edge = 0) at which the result is taken.
    task automatic wait_result(output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= LAT_LIMIT; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                lat = c + 1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        vec_t e;
        bit   ok;
        bit   got;
        int   lat;
        if (hold > 0) out_ready = 1'b0;
        start_op(v, ok);
        if (ok) begin
            sb_q.push_back(v);
            n_vec++;
            wait_result(lat, got);
            check("out_valid_seen", {63'd0, got}, 64'd1);
            e = sb_q.pop_front();
            if (got) begin
                check("latency", 64'(lat), 64'(e.exp_lat));
                check("hi", {32'd0, hi}, {32'd0, e.exp_hi});
                check("lo", {32'd0, lo}, {32'd0, e.exp_lo});
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.exp_dbz});
                for (int k = 0; k < hold; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("stall_out_valid", {63'd0, out_valid}, 64'd1);
                    check("stall_hilo", {hi, lo}, {e.exp_hi, e.exp_lo});
                    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                end
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("in_ready_after", {63'd0, in_ready}, 64'd1);
                check("out_valid_after", {63'd0, out_valid}, 64'd0);
                check("busy_after", {63'd0, busy}, 64'd0);
            end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        bit   ok;
        bit   got;
        int   lat;

        vecs[0]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 18};
        vecs[1]  = '{3'b011, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[2]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,        32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[3]  = '{3'b010, 32'd5,        32'd0,        32'd0, 32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 2};
        vecs[4]  = '{3'b010, 32'd100,      32'd7,        32'd0, 32'd0,        32'd2,        32'd14,       1'b0, 34};
        vecs[5]  = '{3'b111, 32'd3,        32'd4,        32'd0, 32'd10,       32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 18};
        vecs[6]  = '{3'b100, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 18};
        vecs[7]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFE, 32'h00000001, 1'b0, 18};
        vecs[8]  = '{3'b101, 32'hFFFFFFFF, 32'd5,        32'd1, 32'd0,        32'h00000000, 32'hFFFFFFFB, 1'b0, 18};
        vecs[9]  = '{3'b011, 32'd7,        32'hFFFFFFFE, 32'd0, 32'd0,        32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[10] = '{3'b110, 32'd2,        32'd3,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 18};
        vecs[11] = '{3'b011, 32'hFFFFFFF8, 32'd0,        32'd0, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 2};

        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], 0);
        end

        // Flush in the same cycle as a request: it must not be accepted.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'b000; srca = 32'd2; srcb = 32'd2;
        #1 check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_no_accept_busy", {63'd0, busy}, 64'd0);

        // DIV aborted by flush at cycle 10, then an immediate MULTU.
        start_op(vecs[4], ok);
        if (ok) begin
            repeat (9) @(posedge clk);
            @(negedge clk);
            check("div_busy_before_flush", {63'd0, busy}, 64'd1);
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            @(negedge clk);
            check("flush_busy", {63'd0, busy}, 64'd0);
            check("flush_out_valid", {63'd0, out_valid}, 64'd0);
            check("flush_in_ready_after", {63'd0, in_ready}, 64'd1);
        end
        run_vec(vecs[7], 0);

        // Consumer stalls DONE for 5 cycles.
        run_vec(vecs[0], 5);

        // Flush while the result waits in DONE: valid drops, hi/lo stay stale.
        out_ready = 1'b0;
        start_op(vecs[5], ok);
        if (ok) begin
            n_vec++;
            wait_result(lat, got);
            check("done_flush_seen", {63'd0, got}, 64'd1);
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            @(negedge clk);
            check("done_flush_out_valid", {63'd0, out_valid}, 64'd0);
            check("done_flush_busy", {63'd0, busy}, 64'd0);
            check("done_flush_hilo", {hi, lo}, {vecs[5].exp_hi, vecs[5].exp_lo});
        end
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a multiply.
        start_op(vecs[8], ok);
        if (ok) begin
            repeat (5) @(posedge clk);
            #2 rst = 1'b0;
            #1;
            check("async_rst_busy", {63'd0, busy}, 64'd0);
            check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("async_rst_hilo", {hi, lo}, 64'd0);
            check("async_rst_dbz", {63'd0, div_by_zero}, 64'd0);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
            check("rst_release_busy", {63'd0, busy}, 64'd0);
        end
        run_vec(vecs[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
